sequence_generator_moore: RTL and testbench
===========================================

// Module: sequence_generator_moore
// PURPOSE
//  Serial bit-pattern transmitter. It is the driving end of the sequence-detector
//  interface: it emits a latched PAT_W-bit pattern MSB-first, one bit per clock,
//  on a 1-bit serial line that feeds a detector's sequence_in.
//  Supports a repeat count and programmable idle gaps, so detector overlap and
//  back-to-back cases can be produced on demand.
//  Moore machine: every output is a registered function of state only.
// PARAMETERS
//  PAT_W    4        pattern length in bits (>=2)
//  CNT_W    8        width of repeat counter
//  GAP_W    4        width of inter-frame gap counter
// PORTS
//  clock         in   1      rising-edge clock
//  reset_n       in   1      async active-low reset
//  start         in   1      request transmission; sampled only in IDLE
//  abort         in   1      sync abort; returns to IDLE, no done
//  pattern       in   PAT_W  bits to send, pattern[PAT_W-1] first
//  repeats       in   CNT_W  number of frames; 0 treated as 1
//  gap           in   GAP_W  idle cycles between frames (0 = back-to-back)
//  sequence_out  out  1      serial data to detector
//  bit_valid     out  1      high while sequence_out carries a pattern bit
//  busy          out  1      high in any state other than IDLE
//  frame_done    out  1      1-cycle pulse coincident with last bit of each frame
//  done          out  1      1-cycle pulse after the final frame
// BEHAVIOUR
//  States: IDLE, SEND, GAP, DONE. Transitions are evaluated in this priority:
//  - reset_n=0 (async): state=IDLE; all outputs=0; all counters/regs cleared.
//  - abort=1 at an edge, any non-IDLE state: next state IDLE; done is not pulsed.
//  - IDLE & start=1: latch pattern, repeats (0->1) and gap; bit_idx=PAT_W-1;
//    next state SEND. start is ignored in all other states.
//  - SEND: sequence_out=pat_q[bit_idx], bit_valid=1, busy=1.
//    - If bit_idx>0: decrement bit_idx.
//    - At bit_idx=0: frame_done=1 and frames_left is decremented.
//      - frames_left==1: go to DONE.
//      - otherwise, gap_q==0: reload bit_idx and stay in SEND.
//      - otherwise: go to GAP with gap_cnt=gap_q.
//  - GAP: sequence_out=0, bit_valid=0, busy=1. gap_cnt is decremented each cycle.
//    After exactly gap_q cycles, reload bit_idx and go to SEND.
//  - DONE: done=1, busy=1, sequence_out=0, then IDLE unconditionally.
//  Latency: first bit appears in the cycle after the edge that samples start.
//  Totals: SEND cycles = PAT_W*repeats; GAP cycles = gap*(repeats-1); DONE = 1 cycle.
//  Changes to pattern/repeats/gap while busy have no effect on the current run.
//  start=1 in the DONE cycle is ignored. A new run needs start high in IDLE.
//  Outputs are driven from registers, never combinationally from inputs.
//  In IDLE: sequence_out=0, bit_valid=0, busy=0, frame_done=0, done=0.
// TESTING
//  1 Pattern=4'b1011, repeats=1, gap=0, start pulse.
//    -> sequence_out 1,0,1,1 on 4 consecutive cycles.
//    -> frame_done on the 4th cycle; done the next cycle; downstream detector fires once.
//  2 Pattern=1011, repeats=3, gap=2.
//    -> line carries 1011 00 1011 00 1011; bit_valid low in the gaps.
//    -> 3 frame_done pulses, then done; busy high for 17 cycles.
//  3 Pattern=1011, repeats=2, gap=0.
//    -> serial stream 10111011 with no idle cycles.
//    -> detector (overlapping) reports 2 detections.
//  4 start re-asserted mid-SEND and pattern changed to 0000 mid-frame.
//    -> both ignored; original frames complete unchanged.
//  5 repeats=0 -> exactly one frame sent.
//    abort in the 1st GAP cycle -> IDLE next cycle, no done.
//  6 reset_n low during the 3rd bit of SEND.
//    -> all outputs 0 immediately (async); IDLE after release.
//    -> a fresh start then sends the full pattern.

Source files
------------

// File: rtl/sequence_generator_moore.sv
// rtl/sequence_generator_moore.sv - serial MSB-first pattern transmitter with repeat count and idle gaps
module sequence_generator_moore #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeats,
  input  logic [GAP_W-1:0] gap,
  output logic             sequence_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             frame_done,
  output logic             done
);

  localparam int IDX_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  logic [PAT_W-1:0] pat_q;
  logic [IDX_W-1:0] bit_idx;
  logic [CNT_W-1:0] frames_left;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_cnt;

  // Outputs are loaded together with the state they belong to, so each one
  // is a pure register read of the current state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      pat_q        <= '0;
      bit_idx      <= '0;
      frames_left  <= '0;
      gap_q        <= '0;
      gap_cnt      <= '0;
      sequence_out <= 1'b0;
      bit_valid    <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      done         <= 1'b0;
    end else if (abort && (state != IDLE)) begin
      state        <= IDLE;
      sequence_out <= 1'b0;
      bit_valid    <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state        <= SEND;
            pat_q        <= pattern;
            frames_left  <= (repeats == '0) ? CNT_W'(1) : repeats;
            gap_q        <= gap;
            bit_idx      <= LAST_IDX;
            sequence_out <= pattern[PAT_W-1];
            bit_valid    <= 1'b1;
            busy         <= 1'b1;
            frame_done   <= 1'b0;
            done         <= 1'b0;
          end
        end

        SEND: begin
          if (bit_idx != '0) begin
            bit_idx      <= bit_idx - IDX_W'(1);
            sequence_out <= pat_q[bit_idx - IDX_W'(1)];
            frame_done   <= (bit_idx == IDX_W'(1));
          end else begin
            frames_left <= frames_left - CNT_W'(1);
            frame_done  <= 1'b0;
            if (frames_left == CNT_W'(1)) begin
              state        <= DONE;
              sequence_out <= 1'b0;
              bit_valid    <= 1'b0;
              done         <= 1'b1;
            end else if (gap_q == '0) begin
              bit_idx      <= LAST_IDX;
              sequence_out <= pat_q[PAT_W-1];
            end else begin
              state        <= GAP;
              gap_cnt      <= gap_q;
              sequence_out <= 1'b0;
              bit_valid    <= 1'b0;
            end
          end
        end

        GAP: begin
          gap_cnt <= gap_cnt - GAP_W'(1);
          // gap_cnt starts at gap_q, so leaving at 1 gives exactly gap_q idle cycles.
          if (gap_cnt == GAP_W'(1)) begin
            state        <= SEND;
            bit_idx      <= LAST_IDX;
            sequence_out <= pat_q[PAT_W-1];
            bit_valid    <= 1'b1;
          end
        end

        DONE: begin
          state        <= IDLE;
          sequence_out <= 1'b0;
          bit_valid    <= 1'b0;
          busy         <= 1'b0;
          frame_done   <= 1'b0;
          done         <= 1'b0;
        end

        default: begin
          state        <= IDLE;
          sequence_out <= 1'b0;
          bit_valid    <= 1'b0;
          busy         <= 1'b0;
          frame_done   <= 1'b0;
          done         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sequence_generator_moore.sv
// tb/tb_sequence_generator_moore.sv - randomized bench for sequence_generator_moore with per-cycle output model
module tb_sequence_generator_moore;
  localparam int PAT_W = 4;
  localparam int CNT_W = 8;
  localparam int GAP_W = 4;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [PAT_W-1:0] pattern = '0;
  logic [CNT_W-1:0] repeats = '0;
  logic [GAP_W-1:0] gap = '0;
  logic             sequence_out;
  logic             bit_valid;
  logic             busy;
  logic             frame_done;
  logic             done;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Expected output vector per future cycle: {sequence_out, bit_valid, busy, frame_done, done}
  logic [4:0] mq[$];

  logic [63:0] run_bits = '0;
  logic [63:0] valid_bits = '0;
  logic [3:0]  det_sr = '0;
  int busy_cycles = 0, fd_count = 0, done_count = 0, det_count = 0;
  int last_fd_at = 0, last_done_at = 0;
  int b0, f0, d0, t0;

  sequence_generator_moore #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
    .pattern(pattern), .repeats(repeats), .gap(gap),
    .sequence_out(sequence_out), .bit_valid(bit_valid), .busy(busy),
    .frame_done(frame_done), .done(done)
  );

  always #5 clock = ~clock;

  // A run is the list of cycles it will occupy; each edge consumes one entry.
  always @(posedge clock) begin
    if (!reset_n) begin
      mq.delete();
    end else if (mq.size() != 0) begin
      if (abort) mq.delete();
      else void'(mq.pop_front());
    end else if (start) begin : build
      int reps;
      reps = (repeats == 0) ? 1 : int'(repeats);
      for (int f = 0; f < reps; f++) begin
        for (int i = PAT_W - 1; i >= 0; i--)
          mq.push_back({pattern[i], 1'b1, 1'b1, (i == 0), 1'b0});
        if (f < reps - 1)
          for (int g = 0; g < int'(gap); g++) mq.push_back(5'b00100);
      end
      mq.push_back(5'b00101);
    end
  end

  always @(negedge reset_n) mq.delete();

  always @(negedge clock) begin
    if (cmp_en) begin : cmp
      logic [4:0] exp_v, act_v;
      exp_v = (mq.size() != 0) ? mq[0] : 5'b00000;
      act_v = {sequence_out, bit_valid, busy, frame_done, done};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL cycle_outputs t=%0t actual=%b required=%b", $time, act_v, exp_v);
      end
    end
  end

  always @(negedge clock) begin
    if (reset_n) begin
      det_sr <= {det_sr[2:0], sequence_out};
      if ({det_sr[2:0], sequence_out} == 4'b1011) det_count <= det_count + 1;
      if (busy) begin
        run_bits    <= {run_bits[62:0], sequence_out};
        busy_cycles <= busy_cycles + 1;
      end
      if (bit_valid) valid_bits <= {valid_bits[62:0], sequence_out};
      if (frame_done) begin
        fd_count   <= fd_count + 1;
        last_fd_at <= busy_cycles + 1;
      end
      if (done) begin
        done_count   <= done_count + 1;
        last_done_at <= busy_cycles + 1;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp_v);
    end
  endtask

  task automatic snap();
    b0 = busy_cycles;
    f0 = fd_count;
    d0 = done_count;
    t0 = det_count;
  endtask

  task automatic start_run(input logic [PAT_W-1:0] p, input logic [CNT_W-1:0] r, input logic [GAP_W-1:0] g);
    @(posedge clock);
    #2;
    pattern = p;
    repeats = r;
    gap     = g;
    start   = 1'b1;
    @(posedge clock);
    #2;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    @(negedge clock);
    while (busy && n < max_cyc) begin
      @(negedge clock);
      n++;
    end
    if (busy) begin
      errors++;
      checks++;
      $display("FAIL wait_idle_timeout actual=busy required=idle");
    end
    #1;
  endtask

  initial begin
    @(posedge clock);
    #1;
    check("reset_outputs", {59'd0, sequence_out, bit_valid, busy, frame_done, done}, 64'd0);
    reset_n = 1'b1;
    cmp_en  = 1'b1;
    repeat (2) @(posedge clock);

    // Single frame, no gap
    snap();
    start_run(4'b1011, 8'd1, 4'd0);
    wait_idle(100);
    check("t1_valid_bits", {60'd0, valid_bits[3:0]}, 64'b1011);
    check("t1_busy_cycles", busy_cycles - b0, 5);
    check("t1_frame_done_cycle", last_fd_at - b0, 4);
    check("t1_done_cycle", last_done_at - b0, 5);
    check("t1_done_count", done_count - d0, 1);
    check("t1_detections", det_count - t0, 1);

    // Three frames separated by two idle cycles
    snap();
    start_run(4'b1011, 8'd3, 4'd2);
    wait_idle(100);
    check("t2_line", {47'd0, run_bits[16:0]}, 64'b10110010110010110);
    check("t2_valid_bits", {52'd0, valid_bits[11:0]}, 64'b101110111011);
    check("t2_busy_cycles", busy_cycles - b0, 17);
    check("t2_frame_done_count", fd_count - f0, 3);
    check("t2_done_count", done_count - d0, 1);

    // Back-to-back frames; overlapping detector sees both
    snap();
    start_run(4'b1011, 8'd2, 4'd0);
    wait_idle(100);
    check("t3_valid_bits", {56'd0, valid_bits[7:0]}, 64'b10111011);
    check("t3_busy_cycles", busy_cycles - b0, 9);
    check("t3_detections", det_count - t0, 2);

    // Inputs changed mid-run must not disturb the latched run
    snap();
    start_run(4'b1101, 8'd2, 4'd1);
    @(posedge clock);
    #2;
    start   = 1'b1;
    pattern = 4'b0000;
    repeats = 8'd9;
    gap     = 4'd7;
    @(posedge clock);
    #2;
    start = 1'b0;
    wait_idle(100);
    check("t4_valid_bits", {56'd0, valid_bits[7:0]}, 64'b11011101);
    check("t4_busy_cycles", busy_cycles - b0, 10);

    // repeats=0 sends exactly one frame
    snap();
    start_run(4'b1011, 8'd0, 4'd3);
    wait_idle(100);
    check("t5_one_frame", fd_count - f0, 1);
    check("t5_busy_cycles", busy_cycles - b0, 5);

    // Abort in the first gap cycle
    snap();
    start_run(4'b1011, 8'd3, 4'd2);
    repeat (4) @(posedge clock);
    #2;
    abort = 1'b1;
    @(negedge clock);
    check("t5_in_gap", {62'd0, bit_valid, busy}, 64'b01);
    @(posedge clock);
    #2;
    abort = 1'b0;
    @(negedge clock);
    check("t5_abort_idle", {62'd0, busy, done}, 64'b00);
    repeat (3) @(negedge clock);
    #1;
    check("t5_abort_no_done", done_count - d0, 0);

    // Async reset during the third bit
    start_run(4'b1011, 8'd2, 4'd0);
    repeat (2) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_async_clear", {59'd0, sequence_out, bit_valid, busy, frame_done, done}, 64'd0);
    @(posedge clock);
    #2;
    reset_n = 1'b1;
    snap();
    start_run(4'b1011, 8'd1, 4'd0);
    wait_idle(100);
    check("t6_fresh_run", {60'd0, valid_bits[3:0]}, 64'b1011);
    check("t6_busy_cycles", busy_cycles - b0, 5);

    // Randomized runs with mid-run input churn and occasional aborts
    for (int r = 0; r < 40; r++) begin
      start_run(4'($urandom), 8'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
      for (int n = 0; n < 200; n++) begin
        @(negedge clock);
        if (!busy) break;
        #3;
        pattern = 4'($urandom);
        repeats = 8'($urandom_range(0, 5));
        gap     = 4'($urandom_range(0, 5));
        start   = 1'($urandom_range(0, 1));
        abort   = ($urandom_range(0, 39) == 0);
      end
      start = 1'b0;
      abort = 1'b0;
      repeat ($urandom_range(0, 2)) @(posedge clock);
    end

    repeat (5) @(posedge clock);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
